cv32e40p_sleep_ctrl_mc: RTL
===========================

Name: cv32e40p_sleep_ctrl_mc

Overview:
Multi-domain successor to the core sleep unit. Gates NUM_DOMAINS independent clock domains (domain 0 = core pipeline; others = LSU/APU/accelerators). Each domain has a per-domain idle-hysteresis FSM and its own clock-gate cell. Gating is released by masked wake events. Sits at the core top level between the ungated clock and all gated sub-clocks.

Parameters:
NUM_DOMAINS, 2, number of gated clock domains (1..8)
NUM_WAKE, 4, number of wake event sources (1..32)
IDLE_CNT_W, 4, width of the idle-hysteresis counter and threshold

Ports:
clk_ungated_i  in  1  free-running clock
rst_n  in  1  reset, asynchronous, active-low
scan_cg_en_i  in  1  scan mode; forces all gates transparent
fetch_enable_i  in  1  fetch-enable request; sticky once seen
fetch_enable_o  out  1  registered sticky fetch enable
busy_i  in  NUM_DOMAINS  per-domain busy
idle_thresh_i  in  IDLE_CNT_W  idle cycles required before gating (quasi-static)
wake_i  in  NUM_WAKE  wake events (level)
wake_mask_i  in  NUM_WAKE  1 = source enabled
clk_gated_o  out  NUM_DOMAINS  gated clocks
domain_sleep_o  out  NUM_DOMAINS  domain d is in GATED
core_sleep_o  out  1  all domains gated
wake_ack_o  out  1  one-cycle pulse after any wake exit
sleep_cycles_o  out  32  sleep statistics (optional feature)

Behaviour:
- Reset values: fetch_enable_o=0, domain_sleep_o=0, core_sleep_o=0, wake_ack_o=0, sleep_cycles_o=0. All FSMs in OFF, counters 0.
- fetch_enable_q <= fetch_enable_q | fetch_enable_i. It never clears except on reset.
- wake = |(wake_i & wake_mask_i), combinational.
- Per-domain FSM, states OFF, ACTIVE, IDLE, GATED:
  - OFF -> ACTIVE when fetch_enable_q=1.
  - ACTIVE: if !busy_i[d] && !wake: go to GATED when thr==0, else go to IDLE with cnt<=1.
  - IDLE: busy_i[d] or wake -> ACTIVE, cnt<=0. Else if cnt>=thr -> GATED. Else cnt++ (saturating).
  - GATED: busy_i[d] or wake -> ACTIVE, cnt<=0.
- Using >= means a threshold lowered mid-count gates on the next cycle.
- clock_en[d] = fetch_enable_q & (state!=GATED | wake | busy_i[d]).
  - Wake and busy re-enable the clock in the same cycle, combinationally. Zero-latency wake; the first gated edge is the next rising edge.
- Each gate is a latch transparent while clk low: en | scan_cg_en_i. Output = latch & clk. Glitch-free.
- domain_sleep_o[d] = (state==GATED), registered.
- core_sleep_o = fetch_enable_q & (&domain_sleep_o) & !wake.
- wake_ack_o: registered pulse, high the cycle after any domain transitions GATED->ACTIVE. Simultaneous exits produce a single pulse.
- Busy and wake together in IDLE: ACTIVE, one transition only.
- Mask cleared while GATED: unmasked events are ignored and the domain stays GATED.
- Reset mid-operation: FSMs go to OFF and clock_en=0, so clocks stop until fetch enable is seen again.
- scan_cg_en_i affects clocks only, never FSM state.

Optional Feature:
Macro CV32E40P_SLEEP_STATS_EN.
- Defined: sleep_cycles_o increments every cycle core_sleep_o=1, saturates at 32'hFFFF_FFFF, clears only on reset.
- Undefined: sleep_cycles_o tied to 0 and the counter is not synthesised.

Decomposition:
- Shared package cv32e40p_sleep_pkg holds:
  - sleep_state_e enum (OFF=2'b00, ACTIVE=2'b01, IDLE=2'b10, GATED=2'b11)
  - MAX_DOMAINS=8
  - MAX_WAKE=32
- Sub-module cv32e40p_sleep_domain holds one FSM, counter and clock-gate instance. The top generates NUM_DOMAINS copies, plus fetch-enable, wake reduction, ack and stats logic.
- The clock gate reuses the existing cv32e40p_clock_gate cell.

Test Plan:
- Reset then fetch_enable_i pulse at cycle 3 -> fetch_enable_o=1 at cycle 4; all domains ACTIVE at cycle 5; clocks toggle.
- thr=3, busy_i=2'b11, then domain 1 goes idle from cycle 10 -> domain 1 is in IDLE on cycles 11-13 and GATED from cycle 14, with clk_gated_o[1] low; domain 0 keeps running.
- All domains gated, then wake_i=4'b0100 with mask 4'b0100 for one cycle -> clocks resume the same cycle; domain_sleep_o=0 next cycle; wake_ack_o single pulse; core_sleep_o drops immediately.
- Same as previous scenario but mask 4'b0000 -> no clock edges, states unchanged, wake_ack_o=0.
- thr=0, then busy_i[0] toggles 1,0,1 -> GATED for exactly one cycle; busy reasserted while gated re-enables the clock combinationally.
- rst_n asserted while all domains gated and sleep_cycles_o=57 (STATS_EN) -> all outputs 0, clocks stopped; the counter restarts from 0 after the next sleep.

Source files
------------

// File: rtl/cv32e40p_sleep_pkg.sv
// Shared types and limits for the multi-domain sleep controller.
package cv32e40p_sleep_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'b00,
    ACTIVE = 2'b01,
    IDLE   = 2'b10,
    GATED  = 2'b11
  } sleep_state_e;

  localparam int MAX_DOMAINS = 8;
  localparam int MAX_WAKE    = 32;

endpackage

// File: rtl/cv32e40p_clock_gate.sv
// Glitch-free clock gate: enable latched while clk is low, ANDed with clk.
module cv32e40p_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic clk_en;

  always_latch begin
    if (!clk_i) clk_en = en_i | scan_cg_en_i;
  end

  assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/cv32e40p_sleep_domain.sv
// One gated clock domain: idle-hysteresis FSM, idle counter and clock gate.
module cv32e40p_sleep_domain
  import cv32e40p_sleep_pkg::*;
#(
  parameter int IDLE_CNT_W = 4
) (
  input  logic                  clk_ungated_i,
  input  logic                  rst_n,
  input  logic                  scan_cg_en_i,
  input  logic                  fetch_enable_i,
  input  logic                  busy_i,
  input  logic                  wake_i,
  input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
  output logic                  clk_gated_o,
  output logic                  sleep_o,
  output logic                  wake_exit_o
);

  sleep_state_e          state_q, state_d;
  logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  activity;
  logic                  clock_en;

  assign activity = busy_i | wake_i;

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OFF: begin
        if (fetch_enable_i) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!activity) begin
          if (idle_thresh_i == '0) begin
            state_d = GATED;
          end else begin
            state_d = IDLE;
            cnt_d   = IDLE_CNT_W'(1);
          end
        end
      end
      IDLE: begin
        if (activity) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else if (cnt_q >= idle_thresh_i) begin
          // >= so a threshold lowered mid-count gates immediately
          state_d = GATED;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + IDLE_CNT_W'(1);
        end
      end
      GATED: begin
        if (activity) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Wake/busy bypass the FSM so the very next edge is delivered.
  assign clock_en    = fetch_enable_i & ((state_q != GATED) | activity);
  assign sleep_o     = (state_q == GATED);
  assign wake_exit_o = (state_q == GATED) & activity;

  cv32e40p_clock_gate u_clock_gate (
    .clk_i        (clk_ungated_i),
    .en_i         (clock_en),
    .scan_cg_en_i (scan_cg_en_i),
    .clk_o        (clk_gated_o)
  );

endmodule

// File: rtl/cv32e40p_sleep_ctrl_mc.sv
// Multi-domain sleep controller: per-domain gating, wake reduction, ack pulse.
// Optional sleep-cycle statistics enabled by CV32E40P_SLEEP_STATS_EN.
module cv32e40p_sleep_ctrl_mc
  import cv32e40p_sleep_pkg::*;
#(
  parameter int NUM_DOMAINS = 2,
  parameter int NUM_WAKE    = 4,
  parameter int IDLE_CNT_W  = 4
) (
  input  logic                   clk_ungated_i,
  input  logic                   rst_n,
  input  logic                   scan_cg_en_i,
  input  logic                   fetch_enable_i,
  output logic                   fetch_enable_o,
  input  logic [NUM_DOMAINS-1:0] busy_i,
  input  logic [IDLE_CNT_W-1:0]  idle_thresh_i,
  input  logic [NUM_WAKE-1:0]    wake_i,
  input  logic [NUM_WAKE-1:0]    wake_mask_i,
  output logic [NUM_DOMAINS-1:0] clk_gated_o,
  output logic [NUM_DOMAINS-1:0] domain_sleep_o,
  output logic                   core_sleep_o,
  output logic                   wake_ack_o,
  output logic [31:0]            sleep_cycles_o
);

  logic                   fetch_enable_q;
  logic                   wake_ack_q;
  logic                   wake;
  logic [NUM_DOMAINS-1:0] wake_exit;

  assign wake = |(wake_i & wake_mask_i);

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      fetch_enable_q <= 1'b0;
      wake_ack_q     <= 1'b0;
    end else begin
      fetch_enable_q <= fetch_enable_q | fetch_enable_i;
      wake_ack_q     <= |wake_exit;
    end
  end

  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_domain
    cv32e40p_sleep_domain #(
      .IDLE_CNT_W (IDLE_CNT_W)
    ) u_domain (
      .clk_ungated_i  (clk_ungated_i),
      .rst_n          (rst_n),
      .scan_cg_en_i   (scan_cg_en_i),
      .fetch_enable_i (fetch_enable_q),
      .busy_i         (busy_i[gi]),
      .wake_i         (wake),
      .idle_thresh_i  (idle_thresh_i),
      .clk_gated_o    (clk_gated_o[gi]),
      .sleep_o        (domain_sleep_o[gi]),
      .wake_exit_o    (wake_exit[gi])
    );
  end

  assign fetch_enable_o = fetch_enable_q;
  assign core_sleep_o   = fetch_enable_q & (&domain_sleep_o) & ~wake;
  assign wake_ack_o     = wake_ack_q;

`ifdef CV32E40P_SLEEP_STATS_EN
  logic [31:0] sleep_cycles_q;

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      sleep_cycles_q <= '0;
    end else if (core_sleep_o && (sleep_cycles_q != 32'hFFFF_FFFF)) begin
      sleep_cycles_q <= sleep_cycles_q + 32'd1;
    end
  end

  assign sleep_cycles_o = sleep_cycles_q;
`else
  assign sleep_cycles_o = '0;
`endif

endmodule
